ieeedrv_rom_arbiter: RTL and testbench
======================================

Name: ieeedrv_rom_arbiter

Overview:
Time-slot arbiter that lets up to 8 drive CPUs share one synchronous ROM port. It holds one ROM image per drive type.
- Each ph2 strobe starts a sweep that snapshots every drive's address and type, then issues them to the ROM one channel per cycle.
- Returned bytes are captured into per-drive hold registers, which stay stable until the next sweep.
- It sits between the per-drive cores and the shared DOS/controller ROM instances. It generalises the fixed 4-drive, single-latency ROM mux in channel count, latency and image count, and adds overrun detection.

Parameters:
NDRV, 4, number of drive channels (1..8)
AW, 14, ROM address width
DW, 8, ROM data width
TW, 1, drive-type width; selects one of 2**TW ROM images
RLAT, 1, ROM read latency in clk_sys cycles from rom_addr/rom_en to rom_q valid (1..3)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ph2  in  1  one-cycle sweep start strobe
drv_addr  in  NDRV x AW  per-drive ROM address (unpacked array)
drv_type  in  NDRV x TW  per-drive type / image select
drv_data  out  NDRV x DW  per-drive held ROM byte
drv_valid  out  NDRV  drv_data[k] holds data from the current sweep
rom_addr  out  AW  shared ROM address
rom_type  out  TW  image select, pipelined with rom_addr
rom_en  out  1  ROM read strobe
rom_q  in  DW  ROM read data
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when the last channel is captured
overrun  out  1  sticky: ph2 arrived while busy

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, including drv_data, drv_valid, rom_addr, rom_type, rom_en, busy, done and overrun. State is IDLE and the pipeline is empty.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On ph2=1, capture drv_addr[*] and drv_type[*] into snapshot registers.
  - Clear drv_valid to 0 and set busy=1 on the next edge. Go to ISSUE with slot=0.
- ISSUE:
  - Each cycle drive rom_addr=snap_addr[slot], rom_type=snap_type[slot], rom_en=1, and push slot into a tag shift register RLAT deep.
  - slot increments. After slot NDRV-1 has been issued, go to DRAIN with rom_en=0.
  - If NDRV=1, ISSUE lasts exactly one cycle.
- Capture path:
  - When a tag emerges RLAT cycles after issue, write rom_q into drv_data[tag] and set drv_valid[tag]=1 on the same edge.
  - Captures proceed in channel order 0..NDRV-1.
- DRAIN:
  - Wait until the last tag is captured; done=1 for that one cycle only.
  - busy falls on the same edge the done pulse rises, then return to IDLE.
- Latency: ph2 to the last drv_valid bit = NDRV+RLAT+1 cycles; channel k is valid at k+RLAT+2.
- ph2 while busy:
  - The strobe is ignored and the sweep continues undisturbed.
  - overrun is set and stays at 1 until reset.
  - ph2 in the same cycle as the done pulse is also an overrun.
- Snapshot rule: changes on drv_addr/drv_type during a sweep do not affect that sweep.
- drv_data[k] retains its value across sweeps until overwritten; only drv_valid is cleared at sweep start.
- Reset mid-sweep: the pipeline is flushed, with no late captures after reset_n rises.
- The slot counter is $clog2(NDRV)+1 bits wide with no wrap-around. Unused tag values are never issued.

Optional Feature:
IEEEDRV_ROMARB_SKIP_EN.
- Defined:
  - Each channel keeps the addr/type of its last completed fetch plus a history-valid bit.
  - In ISSUE, a channel whose snapshot matches its history issues with rom_en=0; its tag is still pushed. On emergence, drv_data is left unchanged and drv_valid is still set.
  - Timing is identical to the non-skip case.
  - History is invalidated on reset.
- Undefined: every slot issues rom_en=1.

Test Plan:
1. NDRV=4, RLAT=1; addrs 0x0010/0x0011/0x0012/0x0013, ROM returns addr[7:0] ^ 0x5A; pulse ph2 -> rom_en high 4 cycles; drv_data = 4A,4B,48,49; done at cycle 6; busy low afterwards.
2. RLAT=3, NDRV=8 -> done exactly 12 cycles after ph2; drv_valid bits rise one per cycle from cycle 5.
3. Change drv_addr[2] from 0x0100 to 0x0200 two cycles after ph2 -> drv_data[2] reflects 0x0100; the next sweep reflects 0x0200.
4. Second ph2 3 cycles after the first (NDRV=4) -> overrun=1 and stays set; the sweep completes normally; no extra sweep is started.
5. Assert reset_n=0 during ISSUE slot 2 -> all outputs 0 asynchronously; after release, no drv_valid or done appears without a new ph2.
6. drv_type={1,0,1,0}, image 0 returns 0x00 and image 1 returns 0xFF -> rom_type sequence 1,0,1,0 and drv_data = FF,00,FF,00. With IEEEDRV_ROMARB_SKIP_EN, a repeated identical sweep gives rom_en=0 on all slots with data unchanged.

Source files
------------

// File: rtl/ieeedrv_rom_arbiter_if.sv
// Shared ROM read port: the arbiter drives it (master), the ROM image bank answers (slave).
interface ieeedrv_rom_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int TW = 1
);
    logic [AW-1:0] rom_addr;
    logic [TW-1:0] rom_type;
    logic          rom_en;
    logic [DW-1:0] rom_q;

    modport master (output rom_addr, output rom_type, output rom_en, input rom_q);
    modport slave  (input rom_addr, input rom_type, input rom_en, output rom_q);
endinterface

// File: rtl/ieeedrv_rom_arbiter.sv
// Time-slot arbiter sharing one synchronous ROM port between NDRV drive CPUs.
// Optional IEEEDRV_ROMARB_SKIP_EN: channels whose address/type repeat their last fetch skip the ROM read.
//
//   state | meaning
//   IDLE  | waiting for ph2; pipeline empty
//   ISSUE | one snapshot channel per cycle onto the ROM port
//   DRAIN | waiting for the last tag to emerge; done pulses on its capture
module ieeedrv_rom_arbiter #(
    parameter int NDRV = 4,
    parameter int AW   = 14,
    parameter int DW   = 8,
    parameter int TW   = 1,
    parameter int RLAT = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ph2,
    input  logic [AW-1:0]         drv_addr [NDRV],
    input  logic [TW-1:0]         drv_type [NDRV],
    output logic [DW-1:0]         drv_data [NDRV],
    output logic [NDRV-1:0]       drv_valid,
    ieeedrv_rom_arbiter_if.master rom,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int SW   = $clog2(NDRV) + 1;
    localparam int TAGW = (NDRV > 1) ? $clog2(NDRV) : 1;
    localparam logic [SW-1:0]   LAST_SLOT = SW'(NDRV - 1);
    localparam logic [TAGW-1:0] LAST_TAG  = TAGW'(NDRV - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state;
    logic [SW-1:0]   slot;
    logic [TAGW-1:0] slot_idx;
    logic [AW-1:0]   snap_addr [NDRV];
    logic [TW-1:0]   snap_type [NDRV];

    // Stage 0 lines up with rom_addr/rom_en, stage RLAT with valid rom_q.
    logic            tag_v    [RLAT+1];
    logic [TAGW-1:0] tag_id   [RLAT+1];
    logic            tag_skip [RLAT+1];

    logic            issue_skip;
    logic            cap_last;

    assign slot_idx = slot[TAGW-1:0];
    assign cap_last = tag_v[RLAT] && (tag_id[RLAT] == LAST_TAG);

`ifdef IEEEDRV_ROMARB_SKIP_EN
    logic [AW-1:0]   hist_addr [NDRV];
    logic [TW-1:0]   hist_type [NDRV];
    logic [NDRV-1:0] hist_v;

    assign issue_skip = hist_v[slot_idx]
                     && (hist_addr[slot_idx] == snap_addr[slot_idx])
                     && (hist_type[slot_idx] == snap_type[slot_idx]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hist_v <= '0;
            for (int i = 0; i < NDRV; i++) begin
                hist_addr[i] <= '0;
                hist_type[i] <= '0;
            end
        end else if (tag_v[RLAT] && !tag_skip[RLAT]) begin
            hist_addr[tag_id[RLAT]] <= snap_addr[tag_id[RLAT]];
            hist_type[tag_id[RLAT]] <= snap_type[tag_id[RLAT]];
            hist_v[tag_id[RLAT]]    <= 1'b1;
        end
    end
`else
    assign issue_skip = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            slot         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            drv_valid    <= '0;
            rom.rom_addr <= '0;
            rom.rom_type <= '0;
            rom.rom_en   <= 1'b0;
            for (int i = 0; i < NDRV; i++) begin
                drv_data[i]  <= '0;
                snap_addr[i] <= '0;
                snap_type[i] <= '0;
            end
            for (int j = 0; j <= RLAT; j++) begin
                tag_v[j]    <= 1'b0;
                tag_id[j]   <= '0;
                tag_skip[j] <= 1'b0;
            end
        end else begin
            done       <= 1'b0;
            rom.rom_en <= 1'b0;
            tag_v[0]   <= 1'b0;
            for (int j = 1; j <= RLAT; j++) begin
                tag_v[j]    <= tag_v[j-1];
                tag_id[j]   <= tag_id[j-1];
                tag_skip[j] <= tag_skip[j-1];
            end

            // A strobe landing on the done cycle is still too late for a clean sweep.
            if (ph2 && (state != IDLE || done))
                overrun <= 1'b1;

            if (tag_v[RLAT]) begin
                drv_valid[tag_id[RLAT]] <= 1'b1;
                if (!tag_skip[RLAT])
                    drv_data[tag_id[RLAT]] <= rom.rom_q;
            end

            case (state)
                IDLE: begin
                    if (ph2 && !done) begin
                        for (int i = 0; i < NDRV; i++) begin
                            snap_addr[i] <= drv_addr[i];
                            snap_type[i] <= drv_type[i];
                        end
                        drv_valid <= '0;
                        busy      <= 1'b1;
                        slot      <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    rom.rom_addr <= snap_addr[slot_idx];
                    rom.rom_type <= snap_type[slot_idx];
                    rom.rom_en   <= !issue_skip;
                    tag_v[0]     <= 1'b1;
                    tag_id[0]    <= slot_idx;
                    tag_skip[0]  <= issue_skip;
                    slot         <= slot + 1'b1;
                    if (slot == LAST_SLOT)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (cap_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ieeedrv_rom_arbiter.sv
// Bench for ieeedrv_rom_arbiter: a 4-channel/latency-1 and an 8-channel/latency-3 instance share ph2 and reset.
module tb_ieeedrv_rom_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic ph2;
    always #5 clk_sys = ~clk_sys;

    logic [13:0] addr [8];
    logic [0:0]  typ  [8];
    logic [13:0] a_addr [4];
    logic [0:0]  a_typ  [4];
    logic [7:0]  a_data [4];
    logic [3:0]  a_valid;
    logic        a_busy, a_done, a_ovr;
    logic [7:0]  b_data [8];
    logic [7:0]  b_valid;
    logic        b_busy, b_done, b_ovr;

    ieeedrv_rom_arbiter_if #(.AW(14), .DW(8), .TW(1)) rom_a ();
    ieeedrv_rom_arbiter_if #(.AW(14), .DW(8), .TW(1)) rom_b ();

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a_addr[k] = addr[k];
            a_typ[k]  = typ[k];
        end
    end

    ieeedrv_rom_arbiter #(.NDRV(4), .AW(14), .DW(8), .TW(1), .RLAT(1)) u_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ph2(ph2),
        .drv_addr(a_addr), .drv_type(a_typ), .drv_data(a_data), .drv_valid(a_valid),
        .rom(rom_a), .busy(a_busy), .done(a_done), .overrun(a_ovr));

    ieeedrv_rom_arbiter #(.NDRV(8), .AW(14), .DW(8), .TW(1), .RLAT(3)) u_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ph2(ph2),
        .drv_addr(addr), .drv_type(typ), .drv_data(b_data), .drv_valid(b_valid),
        .rom(rom_b), .busy(b_busy), .done(b_done), .overrun(b_ovr));

    // Two ROM images: image 1 is the bitwise inverse of image 0.
    function automatic logic [7:0] rom_fn(input logic [13:0] a, input logic [0:0] t);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A ^ {8{t[0]}};
    endfunction

    // ROM models; a non-enabled read returns a poison byte.
    logic [7:0] qa;
    logic [7:0] qb [3];
    always @(posedge clk_sys) begin
        qa    <= rom_a.rom_en ? rom_fn(rom_a.rom_addr, rom_a.rom_type) : 8'hEE;
        qb[0] <= rom_b.rom_en ? rom_fn(rom_b.rom_addr, rom_b.rom_type) : 8'hEE;
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end
    assign rom_a.rom_q = qa;
    assign rom_b.rom_q = qb[2];

    logic [7:0]  obs_data  [2][8];
    logic [7:0]  obs_valid [2];
    logic        obs_busy [2], obs_done [2], obs_ovr [2], obs_en [2];
    logic [13:0] obs_addr [2];
    logic [0:0]  obs_type [2];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            obs_data[0][k] = 8'h00;
            obs_data[1][k] = b_data[k];
        end
        for (int k = 0; k < 4; k++) obs_data[0][k] = a_data[k];
        obs_valid[0] = {4'b0000, a_valid};
        obs_valid[1] = b_valid;
        obs_busy[0]  = a_busy;  obs_busy[1] = b_busy;
        obs_done[0]  = a_done;  obs_done[1] = b_done;
        obs_ovr[0]   = a_ovr;   obs_ovr[1]  = b_ovr;
        obs_en[0]    = rom_a.rom_en;   obs_en[1]   = rom_b.rom_en;
        obs_addr[0]  = rom_a.rom_addr; obs_addr[1] = rom_b.rom_addr;
        obs_type[0]  = rom_a.rom_type; obs_type[1] = rom_b.rom_type;
    end

    // Reference model state
    logic [7:0] mdl_data [2][8];
    logic       mdl_ovr  [2];
`ifdef IEEEDRV_ROMARB_SKIP_EN
    logic [13:0] hist_a [2][8];
    logic [0:0]  hist_t [2][8];
    logic        hist_v [2][8];
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    function automatic string nm(input string s, input int i, input int c);
        return $sformatf("%s_%s@%0d", s, (i == 0) ? "a" : "b", c);
    endfunction

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mdl_ovr[i] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                mdl_data[i][k] = 8'h00;
`ifdef IEEEDRV_ROMARB_SKIP_EN
                hist_v[i][k] = 1'b0;
                hist_a[i][k] = '0;
                hist_t[i][k] = '0;
`endif
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk(nm({tag, "_busy"}, i, 0), 64'(obs_busy[i]), 64'd0);
            chk(nm({tag, "_done"}, i, 0), 64'(obs_done[i]), 64'd0);
            chk(nm({tag, "_ovr"}, i, 0), 64'(obs_ovr[i]), 64'd0);
            chk(nm({tag, "_en"}, i, 0), 64'(obs_en[i]), 64'd0);
            chk(nm({tag, "_addr"}, i, 0), 64'(obs_addr[i]), 64'd0);
            chk(nm({tag, "_type"}, i, 0), 64'(obs_type[i]), 64'd0);
            chk(nm({tag, "_valid"}, i, 0), 64'(obs_valid[i]), 64'd0);
            for (int k = 0; k < nch(i); k++)
                chk(nm($sformatf("%s_data%0d", tag, k), i, 0), 64'(obs_data[i][k]), 64'd0);
        end
    endtask

    // One full sweep, starting and ending just after a falling edge. chg_c: cycle at which
    // addr[2] is rewritten; p2_c: cycle at which a second ph2 is driven (-1 = none).
    task automatic sweep(input int chg_c, input logic [13:0] chg_val, input int p2_c);
        logic [13:0] sa [8];
        logic [0:0]  st [8];
        logic [7:0]  nv [8];
        logic        en [2][8];
        int          done_at [2];
        for (int k = 0; k < 8; k++) begin
            sa[k] = addr[k];
            st[k] = typ[k];
            nv[k] = rom_fn(sa[k], st[k]);
        end
        for (int i = 0; i < 2; i++) begin
            done_at[i] = -1;
            for (int k = 0; k < 8; k++) begin
                en[i][k] = 1'b1;
`ifdef IEEEDRV_ROMARB_SKIP_EN
                en[i][k] = !(hist_v[i][k] && hist_a[i][k] == sa[k] && hist_t[i][k] == st[k]);
`endif
            end
        end
        ph2 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                int n, r;
                logic [7:0] ev;
                logic e_en;
                n = nch(i);
                r = lat(i);
                chk(nm("busy", i, c), 64'(obs_busy[i]), 64'(c <= n + r));
                chk(nm("done", i, c), 64'(obs_done[i]), 64'(c == n + r + 1));
                chk(nm("ovr", i, c), 64'(obs_ovr[i]), 64'(mdl_ovr[i] || (p2_c >= 0 && c >= p2_c + 1)));
                e_en = 1'b0;
                if (c >= 1 && c <= n) e_en = en[i][c-1];
                chk(nm("rom_en", i, c), 64'(obs_en[i]), 64'(e_en));
                if (e_en) begin
                    chk(nm("rom_addr", i, c), 64'(obs_addr[i]), 64'(sa[c-1]));
                    chk(nm("rom_type", i, c), 64'(obs_type[i]), 64'(st[c-1]));
                end
                ev = '0;
                for (int k = 0; k < n; k++) if (c >= k + r + 2) ev[k] = 1'b1;
                chk(nm("valid", i, c), 64'(obs_valid[i]), 64'(ev));
                for (int k = 0; k < n; k++)
                    chk(nm($sformatf("data%0d", k), i, c), 64'(obs_data[i][k]),
                        64'((c >= k + r + 2 && en[i][k]) ? nv[k] : mdl_data[i][k]));
                if (obs_done[i] && done_at[i] < 0) done_at[i] = c;
            end
            ph2 = (c == p2_c);
            if (c == chg_c) addr[2] = chg_val;
        end
        for (int i = 0; i < 2; i++) begin
            chk(nm("done_cycle", i, 0), 64'(done_at[i]), (i == 0) ? 64'd6 : 64'd12);
            if (p2_c >= 0) mdl_ovr[i] = 1'b1;
            for (int k = 0; k < nch(i); k++) begin
                if (en[i][k]) mdl_data[i][k] = nv[k];
`ifdef IEEEDRV_ROMARB_SKIP_EN
                if (en[i][k]) begin
                    hist_v[i][k] = 1'b1;
                    hist_a[i][k] = sa[k];
                    hist_t[i][k] = st[k];
                end
`endif
            end
        end
    endtask

    typedef struct packed {
        logic [7:0][13:0] addr;
        logic [7:0]       typ;
        logic [7:0][7:0]  want;
    } vec_t;
    vec_t vecs [4];

    initial begin
        // Fields are listed channel 7 first, channel 0 last.
        vecs[0].addr = {14'h0023, 14'h0022, 14'h0021, 14'h0020, 14'h0013, 14'h0012, 14'h0011, 14'h0010};
        vecs[0].typ  = 8'h00;
        vecs[0].want = {8'h79, 8'h78, 8'h7B, 8'h7A, 8'h49, 8'h48, 8'h4B, 8'h4A};
        vecs[1].addr = {8{14'h005A}};
        vecs[1].typ  = 8'h55;
        vecs[1].want = {4{16'h00FF}};
        vecs[2]      = vecs[1];
        vecs[3].addr = {14'h00AA, 14'h0055, 14'h00FF, 14'h0100, 14'h12C3, 14'h00A5, 14'h0000, 14'h3FFF};
        vecs[3].typ  = 8'h4C;
        vecs[3].want = {8'hF0, 8'hF0, 8'hA5, 8'h5B, 8'h74, 8'h00, 8'h5A, 8'h9A};

        reset_n = 1'b0;
        ph2     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            addr[k] = '0;
            typ[k]  = '0;
        end
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 8; k++) begin
                addr[k] = vecs[v].addr[k];
                typ[k]  = vecs[v].typ[k];
            end
            sweep(-1, 14'h0, -1);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < nch(i); k++)
                    chk(nm($sformatf("vec%0d_data%0d", v, k), i, 0), 64'(obs_data[i][k]), 64'(vecs[v].want[k]));
        end

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 8; k++) begin
                addr[k] = 14'($urandom_range(0, 16383));
                typ[k]  = 1'($urandom_range(0, 1));
            end
            sweep(-1, 14'h0, -1);
        end

        // Address change mid-sweep only lands in the following sweep.
        addr[2] = 14'h0100;
        typ[2]  = 1'b0;
        sweep(2, 14'h0200, -1);
        for (int i = 0; i < 2; i++) chk(nm("snap_old", i, 0), 64'(obs_data[i][2]), 64'h5B);
        sweep(-1, 14'h0, -1);
        for (int i = 0; i < 2; i++) chk(nm("snap_new", i, 0), 64'(obs_data[i][2]), 64'h58);

        // Second strobe three cycles into a sweep.
        sweep(-1, 14'h0, 2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                chk(nm("post_ovr_busy", i, c), 64'(obs_busy[i]), 64'd0);
                chk(nm("post_ovr_en", i, c), 64'(obs_en[i]), 64'd0);
                chk(nm("post_ovr_sticky", i, c), 64'(obs_ovr[i]), 64'd1);
            end
        end

        // Asynchronous reset with slot 2 about to issue.
        ph2 = 1'b1;
        @(negedge clk_sys);
        ph2 = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_sys);
            for (int i = 0; i < 2; i++) begin
                chk(nm("flush_valid", i, c), 64'(obs_valid[i]), 64'd0);
                chk(nm("flush_done", i, c), 64'(obs_done[i]), 64'd0);
                chk(nm("flush_busy", i, c), 64'(obs_busy[i]), 64'd0);
            end
        end

        for (int k = 0; k < 8; k++) begin
            addr[k] = vecs[0].addr[k];
            typ[k]  = vecs[0].typ[k];
        end
        sweep(-1, 14'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
